// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side consumer for the full-duplex UART core.
// Watches RX_FLAG, captures DATARX into a circular FIFO, and returns a
// one-cycle Clear_RX_Flag acknowledge. Frames with a parity error are
// dropped and counted. The host reads through a show-ahead port.
//
// Ports:
//   clk, reset        clock, asynchronous active-low reset
//   RX_FLAG           byte-ready flag from the UART
//   DATARX            received word (valid while RX_FLAG=1)
//   ParityError       parity flag (valid while RX_FLAG=1)
//   Clear_RX_Flag     one-cycle acknowledge back to the UART
//   rd_en             host pop request
//   rd_data           FIFO head, valid while empty=0
//   empty, full       occupancy status
//   count             occupancy, 0..2**ADDR_WIDTH
//   overrun           sticky: a good byte was dropped on a full FIFO
//   parity_err_cnt    saturating count of dropped parity-error frames
//   clear_errors      synchronous clear of overrun and parity_err_cnt
module uart_rx_fifo #(
  parameter int WORD_LENGTH   = 8,
  parameter int ADDR_WIDTH    = 4,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     RX_FLAG,
  input  logic [WORD_LENGTH-1:0]   DATARX,
  input  logic                     ParityError,
  output logic                     Clear_RX_Flag,
  input  logic                     rd_en,
  output logic [WORD_LENGTH-1:0]   rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [ADDR_WIDTH:0]      count,
  output logic                     overrun,
  output logic [ERR_CNT_WIDTH-1:0] parity_err_cnt,
  input  logic                     clear_errors
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH+1)'(DEPTH);

  typedef enum logic {IDLE, ACK} state_t;
  state_t state, state_nxt;

  logic                   cap, pop, wr, ovf_evt, par_evt;
  logic [ADDR_WIDTH-1:0]  wr_ptr, rd_ptr;
  logic [WORD_LENGTH-1:0] mem [DEPTH];

  // Capture FSM: IDLE samples the flag, ACK holds the acknowledge for
  // exactly one cycle. The UART drops its flag on the edge leaving ACK,
  // so a flag still high in IDLE is always a fresh byte.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    Clear_RX_Flag = 1'b0;
    cap           = 1'b0;
    case (state)
      IDLE: if (RX_FLAG) begin
        cap       = 1'b1;
        state_nxt = ACK;
      end
      ACK: begin
        Clear_RX_Flag = 1'b1;
        state_nxt     = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign rd_data = mem[rd_ptr];

  // A same-cycle pop frees a slot, so a full FIFO still accepts the byte.
  assign pop     = rd_en & ~empty;
  assign wr      = cap & ~ParityError & (~full | pop);
  assign ovf_evt = cap & ~ParityError & full & ~pop;
  assign par_evt = cap & ParityError;

  always_ff @(posedge clk) begin
    if (wr && reset) mem[wr_ptr] <= DATARX;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr)  wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({wr, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Clear first, then apply any same-cycle error event on top of it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overrun        <= 1'b0;
      parity_err_cnt <= '0;
    end else begin
      if (clear_errors) overrun <= ovf_evt;
      else if (ovf_evt) overrun <= 1'b1;

      if (clear_errors)
        parity_err_cnt <= par_evt ? ERR_CNT_WIDTH'(1) : '0;
      else if (par_evt && parity_err_cnt != '1)
        parity_err_cnt <= parity_err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: a queue-based reference model is advanced on
// every rising edge and compared against the DUT on every falling edge,
// plus literal expectations for the directed scenarios and a randomized
// traffic phase.
module tb_uart_rx_fifo;
  localparam int DEPTH = 16;

  logic       clk = 0;
  logic       reset = 0;
  logic       RX_FLAG = 0;
  logic [7:0] DATARX = 0;
  logic       ParityError = 0;
  logic       Clear_RX_Flag;
  logic       rd_en = 0;
  logic [7:0] rd_data;
  logic       empty, full;
  logic [4:0] count;
  logic       overrun;
  logic [7:0] parity_err_cnt;
  logic       clear_errors = 0;

  uart_rx_fifo dut (
    .clk(clk), .reset(reset), .RX_FLAG(RX_FLAG), .DATARX(DATARX),
    .ParityError(ParityError), .Clear_RX_Flag(Clear_RX_Flag),
    .rd_en(rd_en), .rd_data(rd_data), .empty(empty), .full(full),
    .count(count), .overrun(overrun), .parity_err_cnt(parity_err_cnt),
    .clear_errors(clear_errors)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int pulses = 0;
  bit run_chk = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the FIFO is a queue; "acking" marks the cycle after a
  // byte was taken, during which the acknowledge is high and the flag ignored.
  logic [7:0] mq[$];
  bit         m_ack;
  bit         m_ovr;
  int         m_perr;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mq.delete();
      m_ack  = 0;
      m_ovr  = 0;
      m_perr = 0;
    end else begin
      bit take;
      take = !m_ack && RX_FLAG;
      if (clear_errors) begin
        m_ovr  = 0;
        m_perr = 0;
      end
      if (rd_en && mq.size() > 0) void'(mq.pop_front());
      if (take) begin
        if (ParityError) m_perr = (m_perr == 255) ? 255 : m_perr + 1;
        else if (mq.size() < DEPTH) mq.push_back(DATARX);
        else m_ovr = 1;
      end
      m_ack = take;
    end
  end

  always @(negedge clk) begin
    if (run_chk) begin
      chk("clear_rx_flag", Clear_RX_Flag, m_ack);
      chk("count", count, mq.size());
      chk("empty", empty, mq.size() == 0);
      chk("full", full, mq.size() == DEPTH);
      chk("overrun", overrun, m_ovr);
      chk("parity_err_cnt", parity_err_cnt, m_perr);
      if (mq.size() > 0) chk("rd_data", rd_data, mq[0]);
      if (Clear_RX_Flag) pulses++;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // UART-side byte delivery: flag up for the capture cycle and the ACK
  // cycle, then dropped (or replaced by the next byte) after ACK ends.
  task automatic send(input logic [7:0] d, input bit p, input bit rd, input bit clr);
    RX_FLAG = 1; DATARX = d; ParityError = p; rd_en = rd; clear_errors = clr;
    step();
    rd_en = 0; clear_errors = 0;
    step();
    RX_FLAG = 0; ParityError = 0;
  endtask

  task automatic pop_expect(input string name, input logic [7:0] exp);
    chk(name, rd_data, exp);
    rd_en = 1;
    step();
    rd_en = 0;
  endtask

  initial begin
    step(); step();
    reset = 1;
    run_chk = 1;
    step();

    // 1: post-reset state
    chk("rst_empty", empty, 1);
    chk("rst_count", count, 0);
    chk("rst_clear", Clear_RX_Flag, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_perr", parity_err_cnt, 0);

    // 2: single byte, one-cycle ack, then pop
    RX_FLAG = 1; DATARX = 8'hA5;
    step();
    chk("t2_ack_hi", Clear_RX_Flag, 1);
    chk("t2_count", count, 1);
    chk("t2_data", rd_data, 8'hA5);
    step();
    RX_FLAG = 0;
    chk("t2_ack_lo", Clear_RX_Flag, 0);
    step();
    pop_expect("t2_pop", 8'hA5);
    chk("t2_empty", empty, 1);

    // 3: fill across the pointer wrap, overflow, drain in order
    for (int i = 0; i < 16; i++) send(8'(i), 0, 0, 0);
    send(8'hFF, 0, 0, 0);
    chk("t3_full", full, 1);
    chk("t3_count", count, 16);
    chk("t3_overrun", overrun, 1);
    for (int i = 0; i < 16; i++) pop_expect("t3_order", 8'(i));
    chk("t3_empty", empty, 1);

    // 4: parity frames dropped and counted, then cleared
    for (int i = 0; i < 3; i++) send(8'h55, 1, 0, 0);
    chk("t4_count", count, 0);
    chk("t4_perr", parity_err_cnt, 3);
    clear_errors = 1; step(); clear_errors = 0;
    chk("t4_perr_clr", parity_err_cnt, 0);
    chk("t4_ovr_clr", overrun, 0);

    // 5: full FIFO, good byte with same-cycle pop
    for (int i = 0; i < 16; i++) send(8'h20 + 8'(i), 0, 0, 0);
    send(8'h3C, 0, 1, 0);
    chk("t5_count", count, 16);
    chk("t5_overrun", overrun, 0);
    for (int i = 1; i < 16; i++) pop_expect("t5_order", 8'h20 + 8'(i));
    pop_expect("t5_last", 8'h3C);
    chk("t5_empty", empty, 1);

    // 6: back-to-back bytes with the flag re-raised in ACK, then reset
    pulses = 0;
    send(8'h10, 0, 0, 0);
    send(8'h11, 0, 0, 0);
    step();
    chk("t6_pulses", pulses, 2);
    chk("t6_count", count, 2);
    pop_expect("t6_first", 8'h10);
    pop_expect("t6_second", 8'h11);
    for (int i = 0; i < 3; i++) send(8'h40 + 8'(i), 0, 0, 0);
    RX_FLAG = 1; DATARX = 8'h77;
    step();
    reset = 0;
    #1;
    chk("t6_rst_count", count, 0);
    chk("t6_rst_ack", Clear_RX_Flag, 0);
    chk("t6_rst_empty", empty, 1);
    RX_FLAG = 0;
    step();
    reset = 1;
    step();
    chk("t6_idle", Clear_RX_Flag, 0);

    // parity counter saturation and clear colliding with an event
    for (int i = 0; i < 260; i++) send(8'(i), 1, 0, 0);
    chk("sat_perr", parity_err_cnt, 255);
    send(8'h00, 1, 0, 1);
    chk("clr_evt_perr", parity_err_cnt, 1);

    // randomized traffic; read rate varies by phase so the FIFO both
    // fills and drains
    for (int ph = 0; ph < 4; ph++) begin
      for (int n = 0; n < 150; n++) begin
        int rd_pct;
        rd_pct = (ph % 2 == 0) ? 15 : 70;
        if ($urandom_range(99) < 60) begin
          RX_FLAG = 1;
          DATARX = 8'($urandom);
          ParityError = ($urandom_range(7) == 0);
          for (int k = 0; k < 2; k++) begin
            rd_en = ($urandom_range(99) < rd_pct);
            clear_errors = ($urandom_range(31) == 0);
            step();
          end
          RX_FLAG = 0; ParityError = 0;
        end else begin
          rd_en = ($urandom_range(99) < rd_pct);
          clear_errors = ($urandom_range(31) == 0);
          step();
        end
        rd_en = 0; clear_errors = 0;
      end
    end

    step(); step();
    run_chk = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
